// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage : instruction-fetch stage of the pipeline.
//
// Holds the PC, chooses the next PC (sequential, branch target or jump
// target) and owns the IF/ID pipeline register. The instruction memory is
// addressed by pc_out and returns instr_in combinationally in the same cycle.
//
// Next-state priority each rising edge (rst_n high):
//   branch redirect > jump redirect > stall > halted bubble > sequential fetch
// Redirects flush IF/ID even while stalled.
//
// Ports:
//   clk, rst_n              clock (rising edge), synchronous active-low reset
//   stall                   hold PC and IF/ID
//   br_taken, br_pc4,       taken branch redirect, PC+4 of redirecting
//   br_imm                  instruction, signed word-offset immediate
//   j_en, j_index           jump redirect and its 26-bit index field
//   pc_out                  current PC (instruction memory address)
//   instr_in                instruction read at pc_out
//   ifid_instr, ifid_pc4,   IF/ID register contents handed to decode
//   ifid_valid
//   halted                  combinational: pc_out > LAST_PC
//
// Optional feature, macro IF_STAGE_PERF_CNT_EN:
//   perf_fetched            count of sequential-fetch cycles
//   perf_bubbles            count of bubble cycles (redirects and halted)
// -----------------------------------------------------------------------------
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter logic [31:0] LAST_PC  = 32'd40
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_pc4,
    input  logic [15:0] br_imm,
    input  logic        j_en,
    input  logic [25:0] j_index,
    output logic [31:0] pc_out,
    input  logic [31:0] instr_in,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid,
    output logic        halted
`ifdef IF_STAGE_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_bubbles
`endif
);

    logic [31:0] r_pc;
    logic [31:0] r_ifid_instr;
    logic [31:0] r_ifid_pc4;
    logic        r_ifid_valid;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_br_tgt;
    logic [31:0] w_j_tgt;
    logic        w_halted;

    logic [31:0] w_pc_nxt;
    logic [31:0] w_instr_nxt;
    logic [31:0] w_pc4_nxt;
    logic        w_valid_nxt;
    logic        w_fetch;
    logic        w_bubble;

    // Redirect targets and sequential PC; all arithmetic wraps modulo 2^32.
    always_comb begin
        w_pc_plus4 = r_pc + 32'd4;
        w_br_tgt   = br_pc4 + {{14{br_imm[15]}}, br_imm, 2'b00};
        w_j_tgt    = {br_pc4[31:28], j_index, 2'b00};
        w_halted   = (r_pc > LAST_PC);
    end

    // Next PC / IF/ID selection in priority order; defaults hold state.
    always_comb begin
        w_pc_nxt    = r_pc;
        w_instr_nxt = r_ifid_instr;
        w_pc4_nxt   = r_ifid_pc4;
        w_valid_nxt = r_ifid_valid;
        w_fetch     = 1'b0;
        w_bubble    = 1'b0;
        if (br_taken) begin
            w_pc_nxt    = w_br_tgt;
            w_instr_nxt = 32'h0;
            w_pc4_nxt   = 32'h0;
            w_valid_nxt = 1'b0;
            w_bubble    = 1'b1;
        end else if (j_en) begin
            w_pc_nxt    = w_j_tgt;
            w_instr_nxt = 32'h0;
            w_pc4_nxt   = 32'h0;
            w_valid_nxt = 1'b0;
            w_bubble    = 1'b1;
        end else if (stall) begin
            w_pc_nxt    = r_pc;
        end else if (w_halted) begin
            // Beyond the populated program: keep PC, feed decode a bubble.
            w_pc_nxt    = r_pc;
            w_instr_nxt = 32'h0;
            w_pc4_nxt   = 32'h0;
            w_valid_nxt = 1'b0;
            w_bubble    = 1'b1;
        end else begin
            w_pc_nxt    = w_pc_plus4;
            w_instr_nxt = instr_in;
            w_pc4_nxt   = w_pc_plus4;
            w_valid_nxt = 1'b1;
            w_fetch     = 1'b1;
        end
    end

    // PC and IF/ID registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc         <= RESET_PC;
            r_ifid_instr <= 32'h0;
            r_ifid_pc4   <= 32'h0;
            r_ifid_valid <= 1'b0;
        end else begin
            r_pc         <= w_pc_nxt;
            r_ifid_instr <= w_instr_nxt;
            r_ifid_pc4   <= w_pc4_nxt;
            r_ifid_valid <= w_valid_nxt;
        end
    end

    assign pc_out     = r_pc;
    assign ifid_instr = r_ifid_instr;
    assign ifid_pc4   = r_ifid_pc4;
    assign ifid_valid = r_ifid_valid;
    assign halted     = w_halted;

`ifdef IF_STAGE_PERF_CNT_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_bubbles;

    // Performance counters; stall cycles raise neither event so they hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_perf_fetched <= 32'd0;
            r_perf_bubbles <= 32'd0;
        end else begin
            r_perf_fetched <= r_perf_fetched + {31'd0, w_fetch};
            r_perf_bubbles <= r_perf_bubbles + {31'd0, w_bubble};
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_bubbles = r_perf_bubbles;
`else
    // Without counters the event strobes have no consumer.
    logic w_unused_evt;
    assign w_unused_evt = w_fetch ^ w_bubble;
`endif

endmodule

// File: tb/tb_if_stage.sv
// -----------------------------------------------------------------------------
// tb_if_stage : scoreboard bench for if_stage.
// The stimulus process drives one cycle of inputs, and after the rising edge
// pushes the expected state into a queue; a monitor on the falling edge pops
// and compares against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_if_stage;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_pc4;
    logic [15:0] br_imm;
    logic        j_en;
    logic [25:0] j_index;
    logic [31:0] pc_out;
    logic [31:0] instr_in;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;
    logic        halted;
`ifdef IF_STAGE_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_bubbles;
`endif

    if_stage #(.RESET_PC(32'd0), .LAST_PC(32'd40)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .br_taken   (br_taken),
        .br_pc4     (br_pc4),
        .br_imm     (br_imm),
        .j_en       (j_en),
        .j_index    (j_index),
        .pc_out     (pc_out),
        .instr_in   (instr_in),
        .ifid_instr (ifid_instr),
        .ifid_pc4   (ifid_pc4),
        .ifid_valid (ifid_valid),
        .halted     (halted)
`ifdef IF_STAGE_PERF_CNT_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_bubbles (perf_bubbles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: 11-word program at 0..40, zero elsewhere.
    logic [31:0] mem [0:15];
    initial begin
        mem[0]  = 32'h20090001;
        mem[1]  = 32'h200A0005;
        mem[2]  = 32'h21290001;
        mem[3]  = 32'h012A582A;
        mem[4]  = 32'h1560FFFD;
        mem[5]  = 32'hAC090000;
        mem[6]  = 32'h8C0B0000;
        mem[7]  = 32'h016B6020;
        mem[8]  = 32'h08000000;
        mem[9]  = 32'h00000020;
        mem[10] = 32'h3C0D1234;
        mem[11] = 32'h0;
        mem[12] = 32'h0;
        mem[13] = 32'h0;
        mem[14] = 32'h0;
        mem[15] = 32'h0;
    end
    assign instr_in = (pc_out <= 32'd40) ? mem[pc_out[5:2]] : 32'h0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        v;
        logic        h;
        logic [31:0] f;
        logic [31:0] b;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    logic [31:0] m_fetched = 32'd0;
    logic [31:0] m_bubbles = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req)
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        else
            n_pass++;
    endtask

    // Monitor: compare DUT state against the oldest pending expectation.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("pc_out",     pc_out,              e.pc);
            chk("ifid_instr", ifid_instr,          e.instr);
            chk("ifid_pc4",   ifid_pc4,            e.pc4);
            chk("ifid_valid", {31'd0, ifid_valid}, {31'd0, e.v});
            chk("halted",     {31'd0, halted},     {31'd0, e.h});
`ifdef IF_STAGE_PERF_CNT_EN
            chk("perf_fetched", perf_fetched, e.f);
            chk("perf_bubbles", perf_bubbles, e.b);
`endif
        end
    end

    // kind: 0 hold, 1 fetch, 2 bubble, 3 reset (drives counter expectations)
    task automatic step(input logic rn, input logic st, input logic bt,
                        input logic [31:0] bp4, input logic [15:0] imm,
                        input logic je, input logic [25:0] ji,
                        input logic [31:0] e_pc, input logic [31:0] e_instr,
                        input logic [31:0] e_pc4, input logic e_v, input int kind);
        exp_t e;
        rst_n = rn; stall = st; br_taken = bt; br_pc4 = bp4;
        br_imm = imm; j_en = je; j_index = ji;
        @(posedge clk);
        if (kind == 3) begin m_fetched = 32'd0; m_bubbles = 32'd0; end
        else if (kind == 1) m_fetched = m_fetched + 32'd1;
        else if (kind == 2) m_bubbles = m_bubbles + 32'd1;
        e.pc = e_pc; e.instr = e_instr; e.pc4 = e_pc4; e.v = e_v;
        e.h = (e_pc > 32'd40); e.f = m_fetched; e.b = m_bubbles;
        q.push_back(e);
        #1;
    endtask

    // Sequential fetch of the word at address a.
    task automatic fetch(input logic [31:0] a, input logic [31:0] word);
        step(1'b1, 1'b0, 1'b0, 32'd0, 16'd0, 1'b0, 26'd0, a + 32'd4, word, a + 32'd4, 1'b1, 1);
    endtask

    initial begin
        // Reset (held two edges)
        step(1'b0, 1'b0, 1'b0, 32'd0, 16'd0, 1'b0, 26'd0, 32'd0, 32'h0, 32'd0, 1'b0, 3);
        step(1'b0, 1'b1, 1'b1, 32'd64, 16'd4, 1'b1, 26'd3, 32'd0, 32'h0, 32'd0, 1'b0, 3);
        // Free run from 0
        fetch(32'd0,  32'h20090001);
        fetch(32'd4,  32'h200A0005);
        fetch(32'd8,  32'h21290001);
        fetch(32'd12, 32'h012A582A);
        fetch(32'd16, 32'h1560FFFD);
        // Branch back: 24 + (-4 << 2) = 8
        step(1'b1, 1'b0, 1'b1, 32'd24, 16'hFFFC, 1'b0, 26'd0, 32'd8, 32'h0, 32'd0, 1'b0, 2);
        fetch(32'd8,  32'h21290001);
        // Stall three cycles at pc 12
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b1, 1'b0, 32'd0, 16'd0, 1'b0, 26'd0, 32'd12, 32'h21290001, 32'd12, 1'b1, 0);
        fetch(32'd12, 32'h012A582A);
        // Branch + jump + stall together: branch target 16 + 4 = 20 wins
        step(1'b1, 1'b1, 1'b1, 32'd16, 16'd1, 1'b1, 26'd0, 32'd20, 32'h0, 32'd0, 1'b0, 2);
        fetch(32'd20, 32'hAC090000);
        // Plain jump: {4'h0, 2, 00} = 8
        step(1'b1, 1'b0, 1'b0, 32'd28, 16'd0, 1'b1, 26'd2, 32'd8, 32'h0, 32'd0, 1'b0, 2);
        fetch(32'd8,  32'h21290001);
        // Run to the end of the program
        fetch(32'd12, 32'h012A582A);
        fetch(32'd16, 32'h1560FFFD);
        fetch(32'd20, 32'hAC090000);
        fetch(32'd24, 32'h8C0B0000);
        fetch(32'd28, 32'h016B6020);
        fetch(32'd32, 32'h08000000);
        fetch(32'd36, 32'h00000020);
        fetch(32'd40, 32'h3C0D1234);
        // Halted at 44: bubbles, pc sticks
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b0, 1'b0, 32'd0, 16'd0, 1'b0, 26'd0, 32'd44, 32'h0, 32'd0, 1'b0, 2);
        // Stall while halted holds the bubble without counting it
        step(1'b1, 1'b1, 1'b0, 32'd0, 16'd0, 1'b0, 26'd0, 32'd44, 32'h0, 32'd0, 1'b0, 0);
        // Jump out of halt to 0
        step(1'b1, 1'b0, 1'b0, 32'd48, 16'd0, 1'b1, 26'd0, 32'd0, 32'h0, 32'd0, 1'b0, 2);
        fetch(32'd0,  32'h20090001);
        fetch(32'd4,  32'h200A0005);
        // Reset during stall and redirect clears everything
        step(1'b0, 1'b1, 1'b1, 32'd100, 16'd8, 1'b0, 26'd0, 32'd0, 32'h0, 32'd0, 1'b0, 3);
        fetch(32'd0,  32'h20090001);
        // Branch target wrapping below zero: 4 + (-2 << 2) = 0xFFFFFFFC (halted)
        step(1'b1, 1'b0, 1'b1, 32'd4, 16'hFFFE, 1'b0, 26'd0, 32'hFFFFFFFC, 32'h0, 32'd0, 1'b0, 2);
        step(1'b1, 1'b0, 1'b0, 32'd0, 16'd0, 1'b0, 26'd0, 32'hFFFFFFFC, 32'h0, 32'd0, 1'b0, 2);
        // Jump keeps br_pc4[31:28]: {4'hA, 1, 00} = 0xA0000004 (halted)
        step(1'b1, 1'b0, 1'b0, 32'hA0000010, 16'd0, 1'b1, 26'd1, 32'hA0000004, 32'h0, 32'd0, 1'b0, 2);
        step(1'b1, 1'b0, 1'b0, 32'd0, 16'd0, 1'b0, 26'd0, 32'hA0000004, 32'h0, 32'd0, 1'b0, 2);
        @(negedge clk);
        #1;
        n_checks++;
        if (q.size() != 0)
            $display("FAIL drain: got %0d pending expected 0", q.size());
        else
            n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
